// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: controller FSM for a repeated-addition multiplier (P = A * B).
// Drives the operand bus select, the A register, the B down-counter and the
// product register, and reports completion via a start/done handshake.
// Optional feature macro: MUL_SEQ_CTRL_ZERO_SKIP_EN (finish early when A == 0).
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] bout,
    input  logic [WIDTH-1:0] a_val,
    output logic             opsel,
    output logic             lda,
    output logic             ldb,
    output logic             clrp,
    output logic             ldp,
    output logic             decb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        CHK  = 3'd3,
        ADD  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   eqz;
    logic   finish;

    assign eqz = (bout == '0);

`ifdef MUL_SEQ_CTRL_ZERO_SKIP_EN
    assign finish = eqz || (a_val == '0);
`else
    logic unused_a_val;
    assign unused_a_val = ^a_val;
    assign finish       = eqz;
`endif

    // State register; reset forces IDLE immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort out of any busy state wins over everything else
    always_comb begin
        state_d = state_q;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start && !abort) state_d = LDA;
                LDA:     state_d = LDB;
                LDB:     state_d = CHK;
                CHK:     state_d = finish ? DONE : ADD;
                ADD:     state_d = CHK;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore output decode from the state register only
    always_comb begin
        opsel = 1'b0;
        lda   = 1'b0;
        ldb   = 1'b0;
        clrp  = 1'b0;
        ldp   = 1'b0;
        decb  = 1'b0;
        done  = 1'b0;
        busy  = (state_q != IDLE);
        case (state_q)
            LDA: begin
                lda = 1'b1;
            end
            LDB: begin
                ldb   = 1'b1;
                clrp  = 1'b1;
                opsel = 1'b1;
            end
            ADD: begin
                ldp  = 1'b1;
                decb = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Iteration counter: cleared leaving LDA, bumped leaving ADD, frozen on abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt <= '0;
        end else if (!abort) begin
            if (state_q == LDA) begin
                iter_cnt <= '0;
            end else if (state_q == ADD) begin
                iter_cnt <= iter_cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: self-checking bench for mul_seq_ctrl with a behavioural
// datapath (A register, B down-counter, product register) and a cycle-index
// reference model of the expected handshake.
// Honours MUL_SEQ_CTRL_ZERO_SKIP_EN when compiled with the same define.
module tb_mul_seq_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] bout;
    logic [W-1:0] a_val;
    logic         opsel;
    logic         lda;
    logic         ldb;
    logic         clrp;
    logic         ldp;
    logic         decb;
    logic         busy;
    logic         done;
    logic [W-1:0] iter_cnt;

    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [W-1:0] bus;
    logic [W-1:0] aReg;
    logic [W-1:0] bCnt;
    logic [31:0]  pReg;

    int           passCount;
    int           checkCount;
    logic [W-1:0] lastIter;

    mul_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .bout     (bout),
        .a_val    (a_val),
        .opsel    (opsel),
        .lda      (lda),
        .ldb      (ldb),
        .clrp     (clrp),
        .ldp      (ldp),
        .decb     (decb),
        .busy     (busy),
        .done     (done),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus   = opsel ? opB : opA;
    assign bout  = bCnt;
    assign a_val = aReg;

    // Behavioural datapath driven by the controller strobes
    always @(posedge clk) begin
        if (lda) aReg <= bus;
        if (ldb) bCnt <= bus;
        else if (decb) bCnt <= bCnt - 1'b1;
        if (clrp) pReg <= 32'd0;
        else if (ldp) pReg <= pReg + 32'(aReg);
    end

    function automatic logic [7:0] ctlVec();
        return {opsel, lda, ldb, clrp, ldp, decb, busy, done};
    endfunction

    // Expected {opsel,lda,ldb,clrp,ldp,decb,busy,done} in cycle c (LDA = cycle 1)
    function automatic logic [7:0] expVec(int c, int beff, int abortCycle);
        if (abortCycle != 0 && c > abortCycle) return 8'b0000_0000;
        if (c == 1) return 8'b0100_0010;
        if (c == 2) return 8'b1011_0010;
        if (c >= 3 && c <= 2 * beff + 3 && (c % 2) == 1) return 8'b0000_0010;
        if (c >= 4 && c <= 2 * beff + 2 && (c % 2) == 0) return 8'b0000_1110;
        if (c == 2 * beff + 4) return 8'b0000_0011;
        return 8'b0000_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One multiply: start pulse (or held start), optional abort in cycle abortCycle
    task automatic applyStimulus(input int a, input int b, input int abortCycle, input bit holdStart);
        int       beff;
        int       limit;
        logic [W-1:0] iterExp;
        beff = b;
`ifdef MUL_SEQ_CTRL_ZERO_SKIP_EN
        if (a == 0) beff = 0;
`endif
        @(negedge clk);
        opA   = W'(a);
        opB   = W'(b);
        start = 1'b1;
        abort = 1'b0;
        @(posedge clk);
        iterExp = lastIter;
        limit   = (abortCycle != 0) ? abortCycle + 2 : (holdStart ? 2 * beff + 5 : 2 * beff + 6);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (!holdStart) start = 1'b0;
            checkOutput($sformatf("ctl a=%0d b=%0d c%0d", a, b, c), 32'(ctlVec()), 32'(expVec(c, beff, abortCycle)));
            checkOutput($sformatf("iter a=%0d b=%0d c%0d", a, b, c), 32'(iter_cnt), 32'(iterExp));
            abort = (c == abortCycle);
            if (abortCycle == 0 || c < abortCycle) begin
                if (c == 1) iterExp = '0;
                else if (c >= 4 && c <= 2 * beff + 2 && (c % 2) == 0) iterExp = iterExp + 1'b1;
            end
        end
        abort    = 1'b0;
        lastIter = iterExp;
        if (abortCycle == 0) begin
            checkOutput($sformatf("product a=%0d b=%0d", a, b), pReg, 32'(a * beff));
        end
        if (holdStart) begin
            @(negedge clk);
            checkOutput("restart after idle", 32'(ctlVec()), 32'h42);
            start = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            checkOutput("restart aborted", 32'(ctlVec()), 32'h00);
            checkOutput("restart iter frozen", 32'(iter_cnt), 32'(lastIter));
            abort = 1'b0;
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        lastIter   = '0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        opA   = '0;
        opB   = '0;
        aReg  = '0;
        bCnt  = '0;
        pReg  = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset ctl", 32'(ctlVec()), 32'h00);
        checkOutput("reset iter", 32'(iter_cnt), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle ctl %0d", i), 32'(ctlVec()), 32'h00);
            checkOutput($sformatf("idle iter %0d", i), 32'(iter_cnt), 32'h0);
        end

        applyStimulus(5, 3, 0, 1'b0);
        applyStimulus(7, 0, 0, 1'b0);
        applyStimulus(4, 10, 7, 1'b0);
        applyStimulus(0, 4, 0, 1'b0);
        applyStimulus(2, 1, 0, 1'b1);
        applyStimulus(1, 255, 0, 1'b0);

        // start together with abort in IDLE must stay idle
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("start+abort idle", 32'(ctlVec()), 32'h00);
        start = 1'b0;
        abort = 1'b0;

        // Asynchronous reset in the middle of cycle 5
        @(negedge clk);
        opA   = W'(3);
        opB   = W'(6);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset ctl", 32'(ctlVec()), 32'h00);
        checkOutput("async reset iter", 32'(iter_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        lastIter = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post reset idle %0d", i), 32'(ctlVec()), 32'h00);
        end

        for (int n = 0; n < 8; n++) begin
            int a;
            int b;
            int beff;
            int ab;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 12));
            beff = b;
`ifdef MUL_SEQ_CTRL_ZERO_SKIP_EN
            if (a == 0) beff = 0;
`endif
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * beff + 4)) : 0;
            applyStimulus(a, b, ab, 1'b0);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
